// File: rtl/fib_seq_pkg.sv
// Shared constants for the Fibonacci sequence generator: register map, CTRL bits,
// seeds and datapath widths.
package fib_seq_pkg;

  localparam int unsigned ValueW    = 8;
  localparam int unsigned PrescaleW = 16;
  localparam int unsigned WrapW     = 8;

  typedef enum logic [1:0] {
    RegCtrl     = 2'd0,
    RegPrescale = 2'd1,
    RegValue    = 2'd2,
    RegRsvd     = 2'd3
  } reg_sel_e;

  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlClrBit = 1;
  localparam int unsigned CtrlOeBit  = 2;

  localparam logic [ValueW-1:0] SeedA = 8'd0;
  localparam logic [ValueW-1:0] SeedB = 8'd1;

endpackage

// File: rtl/fib_prescaler.sv
// Free-running divider: counts 0..prescale while enabled and emits a one-cycle tick
// on reaching prescale. A clear zeroes the count and suppresses that cycle's tick.
module fib_prescaler
  import fib_seq_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 en,
  input  logic                 clear,
  input  logic [PrescaleW-1:0] prescale,
  output logic                 tick
);

  logic [PrescaleW-1:0] cnt_q, cnt_d;

  assign tick = en && !clear && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Wishbone-controlled 8-bit Fibonacci sequence generator driving io_out, with a
// programmable tick rate and a count of completed sequence wraps.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oeb
);

  logic                 en_q, oe_q, served_q;
  logic [PrescaleW-1:0] prescale_q;
  logic [ValueW-1:0]    a_q, b_q;
  logic                 ovf_q;
  logic [WrapW-1:0]     wrap_q;
  logic [ValueW:0]      sum;
  reg_sel_e             reg_sel;
  logic                 hit, access, wr, wr_ctrl, wr_pre, clr, en_rise, pre_clear, tick;
  logic [31:0]          rdata;
  logic                 unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // served_q blocks a second ack until the master drops stb.
  assign hit     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access  = hit && !served_q;
  assign wr      = access && wbs_we_i;
  assign reg_sel = reg_sel_e'(wbs_adr_i[3:2]);
  assign wr_ctrl = wr && (reg_sel == RegCtrl) && wbs_sel_i[0];
  assign wr_pre  = wr && (reg_sel == RegPrescale);
  assign clr     = wr_ctrl && wbs_dat_i[CtrlClrBit];
  assign en_rise = wr_ctrl && wbs_dat_i[CtrlEnBit] && !en_q;

  assign pre_clear = clr || wr_pre || en_rise;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegCtrl: begin
        rdata[CtrlEnBit] = en_q;
        rdata[CtrlOeBit] = oe_q;
      end
      RegPrescale: rdata[PrescaleW-1:0] = prescale_q;
      RegValue:    rdata = {16'h0, wrap_q, a_q};
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      served_q   <= 1'b0;
      en_q       <= 1'b0;
      oe_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : '0;
      if (!wbs_stb_i) begin
        served_q <= 1'b0;
      end else if (access) begin
        served_q <= 1'b1;
      end
      if (wr_ctrl) begin
        en_q <= wbs_dat_i[CtrlEnBit];
        oe_q <= wbs_dat_i[CtrlOeBit];
      end
      if (wr_pre && wbs_sel_i[0]) prescale_q[7:0]  <= wbs_dat_i[7:0];
      if (wr_pre && wbs_sel_i[1]) prescale_q[15:8] <= wbs_dat_i[15:8];
    end
  end

  fib_prescaler u_prescaler (
    .clock    (clock),
    .resetb   (resetb),
    .en       (en_q),
    .clear    (pre_clear),
    .prescale (prescale_q),
    .tick     (tick)
  );

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // The 9th sum bit marks the step past 233; the following tick restarts from the seeds.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      a_q    <= SeedA;
      b_q    <= SeedB;
      ovf_q  <= 1'b0;
      wrap_q <= '0;
    end else if (clr) begin
      a_q    <= SeedA;
      b_q    <= SeedB;
      ovf_q  <= 1'b0;
      wrap_q <= '0;
    end else if (tick) begin
      if (ovf_q) begin
        a_q    <= SeedA;
        b_q    <= SeedB;
        ovf_q  <= 1'b0;
        wrap_q <= wrap_q + 1'b1;
      end else begin
        a_q          <= b_q;
        {ovf_q, b_q} <= sum;
      end
    end
  end

  assign io_out = a_q;
  assign io_oeb = {8{~oe_q}};

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: register-access vector table with a read-data
// scoreboard, plus hand-written sequences for stepping, freezing, clear and reset.
module tb_fib_seq_gen;

  localparam logic [31:0] Base   = 32'h3000_0000;
  localparam logic [15:0] PreRst = 16'h00A5;
  localparam logic [1:0]  RCtrl  = 2'd0;
  localparam logic [1:0]  RPre   = 2'd1;
  localparam logic [1:0]  RVal   = 2'd2;
  localparam logic [1:0]  RRsvd  = 2'd3;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  io_out, io_oeb;

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_on = 1'b0;
  logic [7:0]  io_at_ack;
  logic [7:0]  seq [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                            8'd55, 8'd89, 8'd144, 8'd233};

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [17];

  always #5 clock = ~clock;

  fib_seq_gen #(
    .BASE_ADDR    (Base),
    .PRESCALE_RST (PreRst)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-data scoreboard: pops one expectation per read ack; data must be 0 when idle.
  always @(negedge clock) begin
    sb_t e;
    if (mon_on) begin
      if (ack && !we) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_unexpected: ack with empty scoreboard, data %h", rdat);
        end else begin
          e = sb_q.pop_front();
          check("rd_data", rdat & e.mask, e.exp & e.mask);
        end
      end else if (!ack) begin
        check("dat_idle", rdat, 32'h0);
      end
    end
  end

  task automatic wb_xfer(input logic w, input logic [1:0] idx, input logic [31:0] d,
                         input logic [3:0] s);
    int waited;
    waited = 0;
    @(posedge clock);
    #1;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = Base | {28'h0, idx, 2'b00};
    wdat = d;
    sel  = s;
    do begin
      @(negedge clock);
      waited++;
    end while (!ack && waited < 8);
    io_at_ack = io_out;
    check("ack_seen", {31'h0, ack}, 32'h1);
    if (ack) begin
      @(negedge clock);
      check("ack_pulse", {31'h0, ack}, 32'h0);
    end else if (!w && sb_q.size() > 0) begin
      sb_q.delete(sb_q.size() - 1);
    end
    @(posedge clock);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    sel = 4'h0;
  endtask

  task automatic wb_read(input logic [1:0] idx, input logic [31:0] exp, input logic [31:0] mask);
    sb_t e;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
    wb_xfer(1'b0, idx, 32'h0, 4'hF);
  endtask

  initial begin
    int waited;
    vecs[0]  = '{1'b0, RVal,  32'h0,         4'hF, 32'h0};
    vecs[1]  = '{1'b0, RPre,  32'h0,         4'hF, {16'h0, PreRst}};
    vecs[2]  = '{1'b0, RRsvd, 32'h0,         4'hF, 32'h0};
    vecs[3]  = '{1'b1, RPre,  32'h0000_1234, 4'h3, 32'h0};
    vecs[4]  = '{1'b0, RPre,  32'h0,         4'hF, 32'h0000_1234};
    vecs[5]  = '{1'b1, RPre,  32'hFFFF_FFFF, 4'h1, 32'h0};
    vecs[6]  = '{1'b0, RPre,  32'h0,         4'hF, 32'h0000_12FF};
    vecs[7]  = '{1'b1, RPre,  32'hFFFF_FFFF, 4'hC, 32'h0};
    vecs[8]  = '{1'b0, RPre,  32'h0,         4'hF, 32'h0000_12FF};
    vecs[9]  = '{1'b1, RCtrl, 32'h0000_0006, 4'h1, 32'h0};
    vecs[10] = '{1'b0, RCtrl, 32'h0,         4'hF, 32'h0000_0004};
    vecs[11] = '{1'b1, RVal,  32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[12] = '{1'b0, RVal,  32'h0,         4'hF, 32'h0};
    vecs[13] = '{1'b1, RCtrl, 32'hFFFF_FFFF, 4'hE, 32'h0};
    vecs[14] = '{1'b0, RCtrl, 32'h0,         4'hF, 32'h0000_0004};
    vecs[15] = '{1'b1, RRsvd, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[16] = '{1'b0, RRsvd, 32'h0,         4'hF, 32'h0};

    #1 resetb = 1'b0;
    #2;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_io_out", 32'(io_out), 32'h0);
    check("rst_io_oeb", 32'(io_oeb), 32'hFF);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetb = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we) wb_xfer(1'b1, vecs[i].idx, vecs[i].data, vecs[i].sel);
      else            wb_read(vecs[i].idx, vecs[i].exp, 32'hFFFF_FFFF);
    end
    check("oe_on_oeb", 32'(io_oeb), 32'h00);
    check("frozen_io_out", 32'(io_out), 32'h0);

    // PRESCALE=0: one step per cycle through a full period and the wrap.
    wb_xfer(1'b1, RPre, 32'h0, 4'h3);
    wb_xfer(1'b1, RCtrl, 32'h5, 4'h1);
    check("run0_first", 32'(io_at_ack), 32'h0);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clock);
      check("run0_step", 32'(io_out), 32'(seq[k % 14]));
    end
    check("run0_oeb", 32'(io_oeb), 32'h00);
    wb_read(RVal, 32'h0000_0100, 32'hFFFF_FF00);

    // PRESCALE=3 with a clear: value changes every 4th cycle.
    wb_xfer(1'b1, RPre, 32'h3, 4'h3);
    wb_xfer(1'b1, RCtrl, 32'h7, 4'h1);
    check("run3_clr", 32'(io_at_ack), 32'h0);
    for (int m = 2; m <= 48; m++) begin
      @(negedge clock);
      check("run3_step", 32'(io_out), 32'(seq[(m / 4) % 14]));
    end

    // Freeze at 55, hold, then re-enable.
    waited = 0;
    while (io_out != 8'd55 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("reach_55", 32'(io_out), 32'd55);
    wb_xfer(1'b1, RCtrl, 32'h4, 4'h1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      check("hold_55", 32'(io_out), 32'd55);
    end
    wb_xfer(1'b1, RCtrl, 32'h5, 4'h1);
    @(negedge clock);
    check("reen_wait", 32'(io_out), 32'd55);
    @(negedge clock);
    check("reen_wait", 32'(io_out), 32'd55);
    @(negedge clock);
    check("reen_next", 32'(io_out), 32'd89);

    // CLR in a cycle that also ticks.
    wb_xfer(1'b1, RPre, 32'h0, 4'h3);
    wb_xfer(1'b1, RCtrl, 32'h7, 4'h1);
    check("clr_tick", 32'(io_at_ack), 32'h0);
    @(negedge clock);
    check("clr_after", 32'(io_out), 32'd1);
    @(negedge clock);
    check("clr_after", 32'(io_out), 32'd2);
    wb_read(RVal, 32'h0, 32'hFFFF_FF00);

    // Address just past the decoded window must never ack.
    @(posedge clock);
    #1;
    cyc = 1'b1;
    stb = 1'b1;
    adr = Base + 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("miss_noack", {31'h0, ack}, 32'h0);
    end
    @(posedge clock);
    #1;
    cyc = 1'b0;
    stb = 1'b0;

    // Reset in the middle of a write.
    @(posedge clock);
    #1;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = 1'b1;
    adr  = Base | 32'h4;
    wdat = 32'h0000_5555;
    sel  = 4'h3;
    #2 resetb = 1'b0;
    @(negedge clock);
    check("rstmid_ack", {31'h0, ack}, 32'h0);
    check("rstmid_io_out", 32'(io_out), 32'h0);
    check("rstmid_oeb", 32'(io_oeb), 32'hFF);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    sel = 4'h0;
    @(negedge clock);
    resetb = 1'b1;
    wb_read(RPre, {16'h0, PreRst}, 32'hFFFF_FFFF);
    wb_read(RVal, 32'h0, 32'hFFFF_FFFF);
    wb_read(RCtrl, 32'h0, 32'hFFFF_FFFF);

    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 Parameter BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes 16 bytes from here.
REQ-002 Parameter PRESCALE_RST, 16'd0, reset value of the PRESCALE register.
REQ-003 Clock and reset: one clock, asynchronous active-low reset.
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 resetb  input  1  asynchronous active-low reset.
REQ-006 wbs_cyc_i  input  1  Wishbone cycle.
REQ-007 wbs_stb_i  input  1  Wishbone strobe.
REQ-008 wbs_we_i  input  1  write enable.
REQ-009 wbs_sel_i  input  4  byte-lane enables.
REQ-010 wbs_adr_i  input  32  byte address.
REQ-011 wbs_dat_i  input  32  write data.
REQ-012 wbs_ack_o  output  1  transfer acknowledge.
REQ-013 wbs_dat_o  output  32  read data.
REQ-014 io_out  output  8  current sequence value, to mprj_io[7:0].
REQ-015 io_oeb  output  8  pad output-enable bar; 0 = drive.

Function
REQ-016 Decode hit SHALL be cyc&stb with wbs_adr_i[31:4]==BASE_ADDR[31:4]; register select is wbs_adr_i[3:2].
REQ-017 Registers: 0 CTRL (bit0 EN, bit1 CLR, bit2 OE), 1 PRESCALE[15:0], 2 VALUE read-only ({16'h0, wrap_cnt[7:0], a[7:0]}), 3 reads 0.
REQ-018 wbs_ack_o SHALL pulse high exactly one cycle, in the cycle after a hit, and SHALL NOT re-assert until stb has been low at least one cycle.
REQ-019 Writes SHALL apply per byte lane per wbs_sel_i; writes to VALUE and register 3 are ignored but still acked.
REQ-020 wbs_dat_o SHALL be valid in the ack cycle and 0 otherwise; CLR always reads 0.
REQ-021 Prescaler: when EN=1, a 16-bit counter counts 0..PRESCALE and emits a one-cycle tick on reaching PRESCALE, then returns to 0; PRESCALE=0 gives a tick every cycle.
REQ-022 Any PRESCALE write or EN 0->1 transition SHALL zero the prescaler counter without a tick that cycle.
REQ-023 Sequence state: a[7:0], b[7:0], ovf (1 bit), wrap_cnt[7:0]; io_out SHALL equal a.
REQ-024 On tick with ovf=0: a<=b; {ovf,b}<=a+b as 9-bit sum.
REQ-025 On tick with ovf=1: a<=0, b<=1, ovf<=0, wrap_cnt<=wrap_cnt+1 (mod 256, wraps 255->0).
REQ-026 Resulting io_out period is 14 ticks: 0,1,1,2,3,5,8,13,21,34,55,89,144,233, then 0.
REQ-027 EN=0 SHALL freeze a, b, ovf, wrap_cnt and the prescaler counter.
REQ-028 Writing CLR=1 SHALL, in the following cycle, set a=0, b=1, ovf=0, wrap_cnt=0 and zero the prescaler; CLR is self-clearing and wins over a simultaneous tick.
REQ-029 io_oeb SHALL equal {8{~OE}}, registered from CTRL with no extra delay.

Reset
REQ-030 On resetb low, immediately: CTRL=0, PRESCALE=PRESCALE_RST, a=0, b=1, ovf=0, wrap_cnt=0, prescaler=0, wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=8'hFF.
REQ-031 Reset asserted mid-transfer SHALL drop any pending ack; no write takes effect.
REQ-032 Reset deassertion SHALL be synchronised externally; the block assumes no deassertion-timing guarantee beyond that.

Structure
REQ-033 Package fib_seq_pkg SHALL hold register offsets, CTRL bit positions, the Fibonacci seed values (0, 1) and widths (value 8, prescale 16, wrap 8).
REQ-034 Sub-module fib_prescaler (counter, tick, clear inputs) SHALL be the only instantiated child; register file and sequence logic live in fib_seq_gen.

Verification
REQ-035 Reset then read VALUE -> 32'h0000_0000; read PRESCALE -> PRESCALE_RST; io_oeb=8'hFF.
REQ-036 Write CTRL=5 (EN, OE), PRESCALE=0 -> io_out steps 0,1,1,2,3,5,8,13,21,34,55,89,144,233,0 on consecutive cycles; io_oeb=8'h00; VALUE[15:8]=1 after the wrap.
REQ-037 PRESCALE=3, EN=1 -> io_out changes exactly every 4 cycles; 5, 55, 144 each observed in order.
REQ-038 Run to io_out=55, write CTRL=4 (EN=0) -> io_out held at 55 for 100 cycles; re-enable -> next value 89 after PRESCALE+1 cycles.
REQ-039 CLR written in the same cycle a tick occurs -> next io_out=0, wrap_cnt=0, no advance that cycle.
REQ-040 Write with wbs_sel_i=4'b0001 to PRESCALE holding 16'h1234, data 32'hFFFF_FFFF -> PRESCALE reads 16'h12FF; ack is a single-cycle pulse for each access.
